io_halt_sequencer: RTL



---
 rtl/io_seq_pkg.sv | 17 +
 rtl/io_halt_sequencer_btn_edge.sv | 39 +++
 rtl/io_halt_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/io_seq_pkg.sv
// Shared types and constants for the I/O halt sequencer.
// Build option: IO_BTN_SYNC_EN (button synchronizer).
package io_seq_pkg;

  localparam int STATE_W        = 3;
  localparam int DEFAULT_DATA_W = 32;
  localparam int HOLD_CNT_W     = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN       = 3'd0,
    ST_WAIT_IN   = 3'd1,
    ST_IN_COMMIT = 3'd2,
    ST_OUT_HOLD  = 3'd3,
    ST_HALTED    = 3'd4
  } io_state_e;

endpackage

// File: rtl/io_halt_sequencer_btn_edge.sv
// Operator button rising-edge detector.
// IO_BTN_SYNC_EN adds a two-flop synchronizer in front.
module btn_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  logic btn_s;
  logic prev_q;

`ifdef IO_BTN_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign btn_s = sync_q[1];
`else
  assign btn_s = btn_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= btn_s;
    end
  end

  assign rise_o = btn_s & ~prev_q;

endmodule

// File: rtl/io_halt_sequencer.sv
// Stall/handshake sequencer for IN, OUT and HALT instructions.
// Build option: IO_BTN_SYNC_EN (synchronized confirm button).
module io_halt_sequencer
  import io_seq_pkg::*;
#(
  parameter int DATA_W          = DEFAULT_DATA_W,
  parameter int OUT_HOLD_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctl_halt,
  input  logic              ctl_in,
  input  logic              ctl_out,
  input  logic              btn_confirm,
  input  logic [DATA_W-1:0] switch_data,
  input  logic [DATA_W-1:0] out_data,
  output logic              pc_en,
  output logic              reg_we_en,
  output logic [DATA_W-1:0] in_value,
  output logic [DATA_W-1:0] display_data,
  output logic              display_valid,
  output logic              waiting_in,
  output logic              halted,
  output logic [STATE_W-1:0] state
);

  localparam bit HAS_HOLD = (OUT_HOLD_CYCLES > 0);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD =
    HAS_HOLD ? HOLD_CNT_W'(OUT_HOLD_CYCLES - 1)
             : '0;

  io_state_e             state_q, state_d;
  logic [DATA_W-1:0]     in_q, in_d;
  logic [DATA_W-1:0]     disp_q, disp_d;
  logic                  valid_q, valid_d;
  logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
  logic                  btn_rise;

  btn_edge_detect u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_confirm),
    .rise_o (btn_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      in_q    <= '0;
      disp_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      disp_q  <= disp_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_d      = in_q;
    disp_d    = disp_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    pc_en     = 1'b1;
    reg_we_en = 1'b1;
    unique case (state_q)
      ST_RUN: begin
        // halt > in > out
        if (ctl_halt) begin
          pc_en     = 1'b0;
          reg_we_en = 1'b0;
          state_d   = ST_HALTED;
        end else if (ctl_in) begin
          pc_en     = 1'b0;
          reg_we_en = 1'b0;
          state_d   = ST_WAIT_IN;
        end else if (ctl_out) begin
          disp_d  = out_data;
          valid_d = 1'b1;
          if (HAS_HOLD) begin
            pc_en   = 1'b0;
            cnt_d   = HOLD_LOAD;
            state_d = ST_OUT_HOLD;
          end
        end
      end
      ST_WAIT_IN: begin
        pc_en     = 1'b0;
        reg_we_en = 1'b0;
        if (btn_rise) begin
          in_d    = switch_data;
          state_d = ST_IN_COMMIT;
        end
      end
      ST_IN_COMMIT: begin
        state_d = ST_RUN;
      end
      ST_OUT_HOLD: begin
        reg_we_en = 1'b0;
        if (cnt_q != '0) begin
          pc_en = 1'b0;
          cnt_d = cnt_q - HOLD_CNT_W'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        pc_en     = 1'b0;
        reg_we_en = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign in_value      = in_q;
  assign display_data  = disp_q;
  assign display_valid = valid_q;
  assign waiting_in    = (state_q == ST_WAIT_IN);
  assign halted        = (state_q == ST_HALTED);
  assign state         = state_q;

endmodule
